// File: rtl/bram_rd_pkg.sv
// rtl/bram_rd_pkg.sv - shared widths, FSM states and lane index type for the BRAM pixel reader.
package bram_rd_pkg;

  localparam int ADDR_W       = 10;
  localparam int DATA_W       = 64;
  localparam int PIX_W        = 16;
  localparam int PIX_PER_WORD = DATA_W / PIX_W;
  localparam int RD_LATENCY   = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef logic [$clog2(PIX_PER_WORD)-1:0] lane_t;

endpackage

// File: rtl/bram_word_fifo2.sv
// rtl/bram_word_fifo2.sv - two-entry word FIFO with combinational head, shared by BRAM reader and writer.
module bram_word_fifo2 #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/bram_pixel_reader.sv
// rtl/bram_pixel_reader.sv - Avalon-MM BRAM read master that unpacks 64-bit words into a 16-bit pixel stream.
module bram_pixel_reader
  import bram_rd_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address,
  output logic              chipselect,
  output logic              write,
  output logic [7:0]        byteenable,
  output logic [DATA_W-1:0] writedata,
  output logic              clken,
  input  logic [DATA_W-1:0] readdata,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sop,
  output logic              pix_eop
);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     issue_left;
  logic [ADDR_W:0]     unpack_left;
  logic                inflight;
  logic [DATA_W-1:0]   word_q;
  lane_t               lane_q;
  logic                pix_valid_q;
  logic                first_q;
  logic                word_first_q;
  logic                word_last_q;

  logic                issue, xfer, last_lane, can_load;
  logic                load_fifo, load_bypass, load;
  logic                fifo_push, fifo_full, fifo_empty;
  logic [1:0]          fifo_count;
  logic [DATA_W-1:0]   fifo_dout, load_data;

  assign write      = 1'b0;
  assign byteenable = 8'hFF;
  assign writedata  = '0;
  assign clken      = 1'b1;

  // Credit: fifo_count + inflight < 2, so a landing word always finds a free slot.
  assign issue      = (state == RUN) && !fifo_full && !(inflight && (fifo_count != 2'd0));
  assign chipselect = issue;
  assign address    = issue ? addr_q : '0;

  assign xfer      = pix_valid_q && pix_ready;
  assign last_lane = (lane_q == lane_t'(PIX_PER_WORD - 1));
  assign can_load  = !pix_valid_q || (xfer && last_lane);

  // A word landing while the FIFO is empty goes straight into the unpacker.
  assign load_fifo   = can_load && !fifo_empty;
  assign load_bypass = can_load && fifo_empty && inflight;
  assign load        = load_fifo || load_bypass;
  assign load_data   = fifo_empty ? readdata : fifo_dout;
  assign fifo_push   = inflight && !load_bypass;

  assign pix_valid = pix_valid_q;
  assign pix_data  = word_q[int'(lane_q)*PIX_W +: PIX_W];
  assign pix_sop   = pix_valid_q && word_first_q && (lane_q == '0);
  assign pix_eop   = pix_valid_q && word_last_q && last_lane;

  bram_word_fifo2 #(.W(DATA_W)) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (fifo_push),
    .din   (readdata),
    .pop   (load_fifo),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (word_count == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (issue && (issue_left == (ADDR_W+1)'(1))) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (pix_eop && pix_ready && !inflight && fifo_empty) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q       <= '0;
      issue_left   <= '0;
      unpack_left  <= '0;
      inflight     <= 1'b0;
      word_q       <= '0;
      lane_q       <= '0;
      pix_valid_q  <= 1'b0;
      first_q      <= 1'b0;
      word_first_q <= 1'b0;
      word_last_q  <= 1'b0;
    end else begin
      inflight <= issue;
      if ((state == IDLE) && start) begin
        addr_q      <= base_addr;
        issue_left  <= word_count;
        unpack_left <= word_count;
        first_q     <= 1'b1;
      end else if (issue) begin
        addr_q     <= addr_q + 1'b1;
        issue_left <= issue_left - 1'b1;
      end
      if (load) begin
        word_q       <= load_data;
        lane_q       <= '0;
        pix_valid_q  <= 1'b1;
        word_first_q <= first_q;
        first_q      <= 1'b0;
        word_last_q  <= (unpack_left == (ADDR_W+1)'(1));
        unpack_left  <= unpack_left - 1'b1;
      end else if (xfer) begin
        if (last_lane) pix_valid_q <= 1'b0;
        else           lane_q      <= lane_q + 1'b1;
      end
    end
  end

endmodule
